// File: rtl/pdm_setpoint_ramp_pkg.sv
// Shared types for the setpoint ramp: FSM state encoding.
package pdm_setpoint_ramp_pkg;
   typedef enum logic {
      IDLE = 1'b0,
      RAMP = 1'b1
   } state_e;
endpackage

// File: rtl/pdm_setpoint_ramp_if.sv
// Target-word valid/ready stream feeding the setpoint ramp.
interface pdm_setpoint_ramp_if #(
   parameter int NBITS = 10
);
   logic [NBITS-1:0] s_tdata;
   logic             s_tvalid;
   logic             s_tready;

   modport master (output s_tdata, output s_tvalid, input  s_tready);
   modport slave  (input  s_tdata, input  s_tvalid, output s_tready);
endinterface

// File: rtl/pdm_tick_gen.sv
// Prescaler: fires a one-cycle tick every (div+1) enabled cycles.
// The counter simply wraps if div is lowered below it; no tick on the wrap.
module pdm_tick_gen #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 en_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   output logic                 tick_o
);
   logic [DIV_WIDTH-1:0] cnt_q;

   assign tick_o = en_i && (cnt_q == div_i);

   // count while enabled, restart on tick or when disabled
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)              cnt_q <= '0;
      else if (!en_i || tick_o) cnt_q <= '0;
      else                      cnt_q <= cnt_q + 1'b1;
   end
endmodule

// File: rtl/pdm_setpoint_ramp.sv
// Slew-rate limiter ahead of the pdm modulator: dout walks toward the
// accepted target by at most 'step' per prescaler tick.
module pdm_setpoint_ramp
   import pdm_setpoint_ramp_pkg::*;
#(
   parameter int NBITS     = 10,
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 resetn,
   pdm_setpoint_ramp_if.slave   s,
   input  logic [NBITS-1:0]     step,
   input  logic [DIV_WIDTH-1:0] div,
   output logic [NBITS-1:0]     dout,
   output logic                 busy,
   output logic                 done
);
   state_e           state_q;
   logic [NBITS-1:0] dout_q, target_q;
   logic             busy_q, done_q;
   logic             tick, accept, up;
   logic [NBITS:0]   diff;
   logic [NBITS-1:0] delta, dout_d;

   // ready is forced low while reset is held, independent of the clock
   assign s.s_tready = resetn && (state_q == IDLE);
   assign accept     = s.s_tvalid && s.s_tready;

   assign dout = dout_q;
   assign busy = busy_q;
   assign done = done_q;

   pdm_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
      .clk    (clk),
      .resetn (resetn),
      .en_i   (state_q == RAMP),
      .div_i  (div),
      .tick_o (tick)
   );

   // clamp step to the remaining distance; step==0 means jump straight there
   always_comb begin
      up     = target_q > dout_q;
      diff   = up ? ({1'b0, target_q} - {1'b0, dout_q})
                  : ({1'b0, dout_q} - {1'b0, target_q});
      delta  = ((step == '0) || ({1'b0, step} > diff)) ? diff[NBITS-1:0] : step;
      dout_d = up ? (dout_q + delta) : (dout_q - delta);
   end

   // FSM with registered busy/done; done is a single-cycle pulse
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         dout_q   <= '0;
         target_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (accept) begin
               target_q <= s.s_tdata;
               if (s.s_tdata == dout_q) begin
                  done_q <= 1'b1;
               end else begin
                  state_q <= RAMP;
                  busy_q  <= 1'b1;
               end
            end
            RAMP: if (tick) begin
               dout_q <= dout_d;
               if (dout_d == target_q) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pdm_setpoint_ramp.sv
// Bench for pdm_setpoint_ramp: vector table, random ramps against a
// closed-form model, and hand sequences for backpressure/reset/div change.
module tb_pdm_setpoint_ramp;
   localparam int NB = 10;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [NB-1:0] step;
   logic [DW-1:0] div;
   logic [NB-1:0] dout;
   logic          busy, done;

   pdm_setpoint_ramp_if #(.NBITS(NB)) s_if ();

   pdm_setpoint_ramp #(.NBITS(NB), .DIV_WIDTH(DW)) dut (
      .clk(clk), .resetn(resetn), .s(s_if.slave),
      .step(step), .div(div), .dout(dout), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int model_dout = 0;

   typedef struct {
      int tgt; int st; int dv; int exp_ticks; int exp_final;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input int n, input int exp_d,
                        input bit exp_b, input bit exp_dn, input bit exp_r);
      logic [NB-1:0] ed;
      ed = exp_d[NB-1:0];
      checks++;
      if (dout !== ed || busy !== exp_b || done !== exp_dn || s_if.s_tready !== exp_r) begin
         errors++;
         $display("FAIL %s n=%0d got dout=%0d busy=%b done=%b rdy=%b want dout=%0d busy=%b done=%b rdy=%b",
                  name, n, dout, busy, done, s_if.s_tready, exp_d, exp_b, exp_dn, exp_r);
      end
   endtask

   task automatic check_int(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   // value after k ticks, straight from the slew rule
   function automatic int model_val(int start, int tgt, int st, int k);
      int v;
      if (k <= 0) return start;
      if (st == 0) return tgt;
      if (tgt > start) begin
         v = start + k * st;
         return (v > tgt) ? tgt : v;
      end
      v = start - k * st;
      return (v < tgt) ? tgt : v;
   endfunction

   function automatic int model_ticks(int start, int tgt, int st);
      int d;
      d = (tgt > start) ? tgt - start : start - tgt;
      if (d == 0) return 0;
      if (st == 0) return 1;
      return (d + st - 1) / st;
   endfunction

   // accept one target, then compare every cycle until one past done
   task automatic do_ramp(input string name, input int tgt, input int st, input int dv,
                          output int nchg, output int fin);
      int start, nt, len, k, w;
      logic [NB-1:0] prev;
      @(negedge clk);
      w = 0;
      while (!s_if.s_tready && w < 2000) begin
         @(negedge clk);
         w++;
      end
      if (!s_if.s_tready) check_int({name, "_ready_timeout"}, 0, 1);
      step = st[NB-1:0]; div = dv[DW-1:0];
      s_if.s_tdata = tgt[NB-1:0]; s_if.s_tvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_if.s_tvalid = 1'b0;
      start = model_dout;
      nt  = model_ticks(start, tgt, st);
      len = nt * (dv + 1);
      prev = start[NB-1:0];
      nchg = 0;
      for (int n = 0; n <= len + 1; n++) begin
         if (n > 0) @(negedge clk);
         k = n / (dv + 1);
         if (k > nt) k = nt;
         check(name, n, model_val(start, tgt, st, k), n < len, n == len, n >= len);
         if (dout !== prev) nchg++;
         prev = dout;
      end
      model_dout = tgt;
      fin = int'(dout);
   endtask

   initial begin
      int nchg, fin, tgt, st, dv, d;
      s_if.s_tdata = '0; s_if.s_tvalid = 1'b0; step = '0; div = '0;

      // reset state
      #23;
      check("reset_hold", 0, 0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); resetn = 1'b1;
      #1 check("reset_release", 0, 0, 1'b0, 1'b0, 1'b1);

      // vector table: {target, step, div, ticks, final}
      vecs.push_back('{120,    0, 0,  1,  120});
      vecs.push_back('{500,    7, 3, 55,  500});
      vecs.push_back('{500,    5, 1,  0,  500});
      vecs.push_back('{900,  100, 1,  4,  900});
      vecs.push_back('{0,   1023, 0,  1,    0});
      vecs.push_back('{900,    0, 2,  1,  900});
      vecs.push_back('{0,      0, 0,  1,    0});
      vecs.push_back('{1023, 1023, 0, 1, 1023});
      vecs.push_back('{1020,   2, 4,  2, 1020});
      foreach (vecs[i]) begin
         do_ramp($sformatf("vec%0d", i), vecs[i].tgt, vecs[i].st, vecs[i].dv, nchg, fin);
         check_int($sformatf("vec%0d_ticks", i), nchg, vecs[i].exp_ticks);
         check_int($sformatf("vec%0d_final", i), fin, vecs[i].exp_final);
      end

      // random ramps against the model
      for (int r = 0; r < 40; r++) begin
         tgt = (($urandom_range(0, 7) == 0) ? model_dout : int'($urandom_range(0, 1023)));
         dv  = int'($urandom_range(0, 5));
         st  = (($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1023)));
         d   = (tgt > model_dout) ? tgt - model_dout : model_dout - tgt;
         if (st != 0 && model_ticks(model_dout, tgt, st) > 60) st = d / 60 + 1;
         do_ramp($sformatf("rnd%0d", r), tgt, st, dv, nchg, fin);
      end

      // backpressure: 0->100 while a second target (50) is held valid
      do_ramp("to_zero", 0, 0, 0, nchg, fin);
      step = 10'd1; div = '0;
      s_if.s_tdata = 10'd100; s_if.s_tvalid = 1'b1;
      @(posedge clk); @(negedge clk);
      s_if.s_tdata = 10'd50;
      for (int n = 0; n <= 100; n++) begin
         if (n > 0) @(negedge clk);
         check("bp_up", n, n, n < 100, n == 100, n >= 100);
      end
      @(posedge clk); @(negedge clk);
      s_if.s_tvalid = 1'b0;
      for (int m = 0; m <= 51; m++) begin
         if (m > 0) @(negedge clk);
         check("bp_down", m, (m > 50) ? 50 : 100 - m, m < 50, m == 50, m >= 50);
      end
      model_dout = 50;

      // reset in the middle of a ramp at dout=300
      do_ramp("to_zero2", 0, 0, 0, nchg, fin);
      step = 10'd10; div = '0;
      s_if.s_tdata = 10'd1000; s_if.s_tvalid = 1'b1;
      @(posedge clk); @(negedge clk);
      s_if.s_tvalid = 1'b0;
      repeat (30) @(posedge clk);
      #2 check("pre_reset", 30, 300, 1'b1, 1'b0, 1'b0);
      resetn = 1'b0;
      #1 check("mid_reset", 0, 0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); resetn = 1'b1;
      #1 check("post_reset_idle", 0, 0, 1'b0, 1'b0, 1'b1);
      model_dout = 0;
      do_ramp("post_reset", 10, 3, 1, nchg, fin);
      check_int("post_reset_ticks", nchg, 4);

      // div 9 -> 2 shortly after the first tick
      step = 10'd10; div = 16'd9;
      @(negedge clk);
      s_if.s_tdata = 10'd110; s_if.s_tvalid = 1'b1;
      @(posedge clk); @(negedge clk);
      s_if.s_tvalid = 1'b0;
      for (int n = 0; n <= 38; n++) begin
         int e;
         if (n > 0) @(negedge clk);
         if (n < 10)      e = 10;
         else if (n < 13) e = 20;
         else             e = 20 + 10 * (1 + (n - 13) / 3);
         if (e > 110) e = 110;
         check("divchg", n, e, n < 37, n == 37, n >= 37);
         if (n == 11) div = 16'd2;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
